// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry, read-mode selectors and a
// constant-evaluable ceil(log2) helper used to size pointers.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 8;
    localparam int FIFO_DEPTH_DEF = 16;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int clog2(input int value);
        int r = 0;
        int v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH dual-port storage: synchronous write, asynchronous read.
module fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered full/empty/almost flags, occupancy count,
// overflow/underflow error pulses and selectable registered or FWFT read.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH_DEF,
    parameter int DEPTH     = FIFO_DEPTH_DEF,
    parameter int PTR_WIDTH = clog2(DEPTH),
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = FIFO_MODE_REG
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_en_i,
    input  logic [WIDTH-1:0]   wdata_i,
    output logic               full_o,
    output logic               afull_o,
    output logic               wr_error_o,
    input  logic               rd_en_i,
    output logic [WIDTH-1:0]   rdata_o,
    output logic               empty_o,
    output logic               aempty_o,
    output logic               rd_error_o,
    output logic [PTR_WIDTH:0] count_o
);

    localparam logic [PTR_WIDTH:0] AFULL_C  = (PTR_WIDTH + 1)'(AFULL_TH);
    localparam logic [PTR_WIDTH:0] AEMPTY_C = (PTR_WIDTH + 1)'(AEMPTY_TH);
    localparam logic [PTR_WIDTH:0] ONE_C    = (PTR_WIDTH + 1)'(1);

    logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0] count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               afull_q, afull_d;
    logic               aempty_q, aempty_d;
    logic               wr_err_q, wr_err_d;
    logic               rd_err_q, rd_err_d;
    logic               wr_acc, rd_acc;
    logic [WIDTH-1:0]   mem_rdata;

    // Acceptance uses the registered flags, so a read frees a slot only
    // for the following cycle's write.
    always_comb begin
        wr_acc   = wr_en_i & ~full_q;
        rd_acc   = rd_en_i & ~empty_q;
        wr_ptr_d = wr_acc ? wr_ptr_q + ONE_C : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + ONE_C : rd_ptr_q;
        count_d  = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
        full_d   = (wr_ptr_d[PTR_WIDTH] != rd_ptr_d[PTR_WIDTH]) &&
                   (wr_ptr_d[PTR_WIDTH-1:0] == rd_ptr_d[PTR_WIDTH-1:0]);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        afull_d  = (count_d >= AFULL_C);
        aempty_d = (count_d <= AEMPTY_C);
        wr_err_d = wr_en_i & full_q;
        rd_err_d = rd_en_i & empty_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(PTR_WIDTH)
    ) u_mem (
        .clk_i  (clk_i),
        .we_i   (wr_acc),
        .waddr_i(wr_ptr_q[PTR_WIDTH-1:0]),
        .wdata_i(wdata_i),
        .raddr_i(rd_ptr_q[PTR_WIDTH-1:0]),
        .rdata_o(mem_rdata)
    );

    // FWFT output is forced to zero while empty so reset clears it too.
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign rdata_o = empty_q ? '0 : mem_rdata;
    end else begin : g_reg
        logic [WIDTH-1:0] rdata_q;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rdata_q <= '0;
            end else if (rd_acc) begin
                rdata_q <= mem_rdata;
            end
        end
        assign rdata_o = rdata_q;
    end

    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign afull_o    = afull_q;
    assign aempty_o   = aempty_q;
    assign wr_error_o = wr_err_q;
    assign rd_error_o = rd_err_q;
    assign count_o    = count_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed checks of sync_fifo_flags in registered (dut) and FWFT (dut_f) modes.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0] wdata = '0;
    logic       full, afull, wr_error, empty, aempty, rd_error;
    logic [7:0] rdata;
    logic [4:0] count;

    logic       f_wr_en = 1'b0, f_rd_en = 1'b0;
    logic [7:0] f_wdata = '0;
    logic       f_full, f_afull, f_wr_error, f_empty, f_aempty, f_rd_error;
    logic [7:0] f_rdata;
    logic [4:0] f_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .FWFT(0)) dut (
        .clk_i(clk), .rst_i(rst),
        .wr_en_i(wr_en), .wdata_i(wdata),
        .full_o(full), .afull_o(afull), .wr_error_o(wr_error),
        .rd_en_i(rd_en), .rdata_o(rdata),
        .empty_o(empty), .aempty_o(aempty), .rd_error_o(rd_error),
        .count_o(count)
    );

    sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .FWFT(1)) dut_f (
        .clk_i(clk), .rst_i(rst),
        .wr_en_i(f_wr_en), .wdata_i(f_wdata),
        .full_o(f_full), .afull_o(f_afull), .wr_error_o(f_wr_error),
        .rd_en_i(f_rd_en), .rdata_o(f_rdata),
        .empty_o(f_empty), .aempty_o(f_aempty), .rd_error_o(f_rd_error),
        .count_o(f_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_aempty", 32'(aempty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_afull", 32'(afull), 0);
        chk("rst_wrerr", 32'(wr_error), 0);
        chk("rst_rderr", 32'(rd_error), 0);
        chk("rst_rdata", 32'(rdata), 0);
        rst = 1'b0;
        tick();

        // FWFT: word visible right after the write edge, popped by rd_en
        f_wr_en = 1'b1; f_wdata = 8'hA5;
        tick();
        f_wr_en = 1'b0;
        chk("fwft_empty_after_wr", 32'(f_empty), 0);
        chk("fwft_rdata", 32'(f_rdata), 32'hA5);
        chk("fwft_count1", 32'(f_count), 1);
        f_rd_en = 1'b1;
        tick();
        chk("fwft_empty_after_pop", 32'(f_empty), 1);
        chk("fwft_count0", 32'(f_count), 0);
        chk("fwft_rderr_none", 32'(f_rd_error), 0);
        tick();
        f_rd_en = 1'b0;
        chk("fwft_rderr_pulse", 32'(f_rd_error), 1);
        tick();
        chk("fwft_rderr_clear", 32'(f_rd_error), 0);

        // Fill 16 words 0x01..0x10 with flag checks at every count
        for (int k = 1; k <= 16; k++) begin
            wr_en = 1'b1; wdata = 8'(k);
            tick();
            chk($sformatf("fill_count%0d", k), 32'(count), 32'(k));
            chk($sformatf("fill_full%0d", k), 32'(full), 32'(k == 16));
            chk($sformatf("fill_afull%0d", k), 32'(afull), 32'(k >= 14));
            chk($sformatf("fill_aempty%0d", k), 32'(aempty), 32'(k <= 2));
            chk($sformatf("fill_empty%0d", k), 32'(empty), 0);
            chk($sformatf("fill_wrerr%0d", k), 32'(wr_error), 0);
        end

        // 17th write rejected
        wdata = 8'h77;
        tick();
        wr_en = 1'b0;
        chk("ovf_wrerr", 32'(wr_error), 1);
        chk("ovf_count", 32'(count), 16);
        chk("ovf_full", 32'(full), 1);
        tick();
        chk("ovf_wrerr_clear", 32'(wr_error), 0);

        // Drain 16 words then one underflow read
        rd_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("drain_data%0d", k), 32'(rdata), 32'(k));
            chk($sformatf("drain_count%0d", k), 32'(count), 32'(16 - k));
            chk($sformatf("drain_rderr%0d", k), 32'(rd_error), 0);
        end
        chk("drain_empty", 32'(empty), 1);
        tick();
        rd_en = 1'b0;
        chk("udf_rderr", 32'(rd_error), 1);
        chk("udf_rdata_hold", 32'(rdata), 32'h10);
        chk("udf_count", 32'(count), 0);
        tick();
        chk("udf_rderr_clear", 32'(rd_error), 0);

        // Refill with 0x21..0x30, then 20 cycles of simultaneous wr/rd
        wr_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            wdata = 8'(8'h21 + k);
            tick();
        end
        chk("refill_full", 32'(full), 1);
        rd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wdata = 8'(8'h41 + i);
            tick();
            chk($sformatf("rw_data%0d", i), 32'(rdata), (i < 16) ? 32'(8'h21 + i) : 32'(8'h32 + i));
            chk($sformatf("rw_wrerr%0d", i), 32'(wr_error), 32'(i == 0));
            chk($sformatf("rw_count%0d", i), 32'(count), 15);
        end
        wr_en = 1'b0;

        // Read 8 more to reach count 7 (queue head is now 0x46)
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        rd_en = 1'b0;
        chk("pre_rst_data", 32'(rdata), 32'h4D);
        chk("pre_rst_count", 32'(count), 7);

        // Asynchronous reset mid-cycle with requests in flight
        wr_en = 1'b1; rd_en = 1'b1; wdata = 8'hEE;
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_aempty", 32'(aempty), 1);
        chk("arst_full", 32'(full), 0);
        chk("arst_afull", 32'(afull), 0);
        chk("arst_rdata", 32'(rdata), 0);
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        rst = 1'b0;
        chk("arst_hold_count", 32'(count), 0);

        // Post-reset round trip of 0x3C
        wr_en = 1'b1; wdata = 8'h3C;
        tick();
        wr_en = 1'b0;
        chk("post_count", 32'(count), 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("post_rdata", 32'(rdata), 32'h3C);
        chk("post_empty", 32'(empty), 1);
        chk("post_rderr", 32'(rd_error), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
